moore_vending_ctrl: RTL and testbench

Parametrised Moore-style vending controller and successor to the fixed-price 2-bit-input vending FSM. It accepts three coin denominations, vends when accumulated credit reaches a configurable price, and returns change or a full refund one unit coin at a time over a valid/ready handshake. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers. All outputs are decoded from registered state only.

---
 rtl/vm_pkg.sv | 17 +
 rtl/vm_coin_decode.sv | 17 +
 rtl/moore_vending_ctrl.sv | 84 ++++++++
 tb/tb_moore_vending_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared state encodings, coin codes and state width for the vending controller
package vm_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_REFUND  = 3'd4
    } state_t;
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_2    = 2'b10,
        COIN_3    = 2'b11
    } coin_t;
endpackage

// File: rtl/vm_coin_decode.sv
// vm_coin_decode: maps a coin code to its credit value
module vm_coin_decode
    import vm_pkg::*;
#(
    parameter int COIN1    = 5,
    parameter int COIN2    = 10,
    parameter int COIN3    = 25,
    parameter int CREDIT_W = 6
) (
    input  logic [1:0]          coin_in,
    output logic [CREDIT_W-1:0] value
);
    always_comb
        value = coin_in == COIN_1 ? CREDIT_W'(COIN1) :
                coin_in == COIN_2 ? CREDIT_W'(COIN2) :
                coin_in == COIN_3 ? CREDIT_W'(COIN3) : '0;
endmodule

// File: rtl/moore_vending_ctrl.sv
// moore_vending_ctrl: Moore vending FSM that collects coins, vends at PRICE and pays change/refunds in unit coins
module moore_vending_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int COIN1    = 5,
    parameter int COIN2    = 10,
    parameter int COIN3    = 25,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                cancel,
    input  logic                coin_out_ready,
    output logic                vend,
    output logic                coin_out_valid,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [STATE_W-1:0]  state
);
    localparam logic [CREDIT_W-1:0] P = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] U = CREDIT_W'(COIN1);
    localparam int MAX_HI = COIN2 > COIN3 ? COIN2 : COIN3;
    if (COIN1 <= 0 || PRICE <= 0 || PRICE % COIN1 != 0 || COIN2 % COIN1 != 0 || COIN3 % COIN1 != 0) begin : g_bad_coin
        $error("moore_vending_ctrl: PRICE/COIN2/COIN3 must be positive multiples of COIN1");
    end
    if (PRICE - COIN1 + MAX_HI >= 2 ** CREDIT_W) begin : g_bad_width
        $error("moore_vending_ctrl: CREDIT_W too narrow for worst-case credit");
    end
    state_t                st, nxt;
    logic [CREDIT_W-1:0]   credit_q, nxt_credit, coin_val, sum;
    vm_coin_decode #(
        .COIN1(COIN1), .COIN2(COIN2), .COIN3(COIN3), .CREDIT_W(CREDIT_W)
    ) u_decode (
        .coin_in(coin_in),
        .value  (coin_val)
    );
    always_comb begin
        sum        = credit_q + coin_val;
        nxt        = st;
        nxt_credit = credit_q;
        case (st)
            ST_IDLE: begin
                nxt_credit = coin_val;
                nxt        = coin_in == COIN_NONE ? ST_IDLE : coin_val >= P ? ST_VEND : ST_COLLECT;
            end
            ST_COLLECT: begin
                nxt_credit = sum;
                nxt        = cancel ? ST_REFUND : sum >= P ? ST_VEND : ST_COLLECT;
            end
            ST_VEND: begin
                nxt_credit = credit_q - P;
                nxt        = credit_q == P ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE, ST_REFUND: begin
                nxt_credit = coin_out_ready ? credit_q - U : credit_q;
                nxt        = coin_out_ready && credit_q == U ? ST_IDLE : st;
            end
            default: begin
                nxt_credit = '0;
                nxt        = ST_IDLE;
            end
        endcase
    end
    // Strobes are registered from the next state so they align with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= ST_IDLE;
            credit_q       <= '0;
            vend           <= 1'b0;
            coin_out_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            st             <= nxt;
            credit_q       <= nxt_credit;
            vend           <= nxt == ST_VEND;
            coin_out_valid <= nxt == ST_CHANGE || nxt == ST_REFUND;
            busy           <= nxt == ST_VEND || nxt == ST_CHANGE || nxt == ST_REFUND;
        end
    end
    assign credit = credit_q;
    assign state  = st;
endmodule

// File: tb/tb_moore_vending_ctrl.sv
// tb_moore_vending_ctrl: directed-vector bench for moore_vending_ctrl with default parameters
module tb_moore_vending_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin_in = 2'b00;
    logic       cancel = 1'b0;
    logic       coin_out_ready = 1'b0;
    logic       vend, coin_out_valid, busy;
    logic [5:0] credit;
    logic [2:0] state;
    int         errors = 0;
    int         checks = 0;
    int         units = 0;

    moore_vending_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .coin_in       (coin_in),
        .cancel        (cancel),
        .coin_out_ready(coin_out_ready),
        .vend          (vend),
        .coin_out_valid(coin_out_valid),
        .busy          (busy),
        .credit        (credit),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Worst-case credit with default parameters is 15-5+25 = 35
    always @(negedge clk)
        if (reset) assert (credit <= 6'd35) else $error("FAIL overflow credit=%0d", credit);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        units += int'(coin_out_valid && coin_out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int st, input int cr, input int v, input int cv, input int b);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".credit"}, int'(credit), cr);
        check({tag, ".vend"}, int'(vend), v);
        check({tag, ".valid"}, int'(coin_out_valid), cv);
        check({tag, ".busy"}, int'(busy), b);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out("rst_hold", 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        expect_out("rst_rel", 0, 0, 0, 0, 0);

        coin_in = 2'b01; tick(); expect_out("exact1", 1, 5, 0, 0, 0);
        tick(); expect_out("exact2", 1, 10, 0, 0, 0);
        tick(); expect_out("exact3", 2, 15, 1, 0, 1);
        coin_in = 2'b00; tick(); expect_out("exact_done", 0, 0, 0, 0, 0);

        coin_out_ready = 1'b1;
        coin_in = 2'b11; tick(); expect_out("over_vend", 2, 25, 1, 0, 1);
        coin_in = 2'b00; tick(); expect_out("over_chg1", 3, 10, 0, 1, 1);
        tick(); expect_out("over_chg2", 3, 5, 0, 1, 1);
        tick(); expect_out("over_done", 0, 0, 0, 0, 0);

        coin_in = 2'b10; tick(); expect_out("ref_c10", 1, 10, 0, 0, 0);
        coin_in = 2'b01; cancel = 1'b1; tick(); expect_out("ref_start", 4, 15, 0, 1, 1);
        coin_in = 2'b00; cancel = 1'b0;
        tick(); expect_out("ref_u1", 4, 10, 0, 1, 1);
        tick(); expect_out("ref_u2", 4, 5, 0, 1, 1);
        tick(); expect_out("ref_done", 0, 0, 0, 0, 0);

        coin_out_ready = 1'b0;
        coin_in = 2'b11; tick(); expect_out("stall_vend", 2, 25, 1, 0, 1);
        coin_in = 2'b00; tick(); expect_out("stall_chg", 3, 10, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stall_hold", 3, 10, 0, 1, 1);
        end
        coin_out_ready = 1'b1;
        tick(); expect_out("stall_d1", 3, 5, 0, 1, 1);
        tick(); expect_out("stall_d2", 0, 0, 0, 0, 0);

        units = 0;
        coin_in = 2'b11; tick(); expect_out("gate_vend", 2, 25, 1, 0, 1);
        tick(); expect_out("gate_chg", 3, 10, 0, 1, 1);
        coin_in = 2'b01; tick(); expect_out("gate_chg2", 3, 5, 0, 1, 1);
        coin_in = 2'b00; tick(); expect_out("gate_done", 0, 0, 0, 0, 0);
        check("gate_units", units, 2);

        coin_in = 2'b10; tick(); expect_out("arst_pre", 1, 10, 0, 0, 0);
        coin_in = 2'b00;
        #2 reset = 1'b0;
        #1 expect_out("arst_async", 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick(); expect_out("arst_after", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
